pwm_duty_sequencer: RTL

Command-driven controller that moves the duty cycle of a 0–10 step PWM generator to a requested target. It emits timed increase/decrease button-style pulses that survive the generator's edge-detect/debounce front end, and it programs the generator's 6-bit clock divisor. It sits between a host or register interface and the PWM generator, and keeps a mirror of the generator's duty value.

---
 rtl/pwm_ctrl_pkg.sv | 33 +++
 rtl/pwm_seq_timer.sv | 29 ++
 rtl/pwm_duty_sequencer.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/pwm_ctrl_pkg.sv
// Shared types and constants for the PWM duty sequencer and its generator.
// Holds the sequencer state encoding and saturating duty step helper.
package pwm_ctrl_pkg;

   localparam int PWM_DUTY_MAX = 10;
   localparam int PWM_DUTY_RST = 5;
   localparam int PWM_DUTY_W   = 4;
   localparam int PWM_DIV_W    = 6;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESS   = 2'd1,
      RELEASE = 2'd2,
      DONE    = 2'd3
   } seq_state_t;

   // One duty step in the requested direction, never leaving 0..max.
   function automatic logic [PWM_DUTY_W-1:0] step_duty(
      input logic [PWM_DUTY_W-1:0] duty,
      input logic                  up,
      input logic [PWM_DUTY_W-1:0] max
   );
      logic [PWM_DUTY_W-1:0] result;
      result = duty;
      if (up) begin
         if (duty < max) result = duty + 1'b1;
      end else begin
         if (duty != '0) result = duty - 1'b1;
      end
      return result;
   endfunction

endpackage

// File: rtl/pwm_seq_timer.sv
// Phase counter shared by the press and release phases of the sequencer.
// expire is high while the count sits on its last value (HOLD_CYCLES-1).
module pwm_seq_timer #(
   parameter int HOLD_CYCLES = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   output logic expire
);

   localparam int CW = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(HOLD_CYCLES - 1);

   logic [CW-1:0] count_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         count_reg <= '0;
      end else if (load) begin
         count_reg <= '0;
      end else if (count_reg != LAST) begin
         count_reg <= count_reg + 1'b1;
      end
   end

   assign expire = (count_reg == LAST);

endmodule

// File: rtl/pwm_duty_sequencer.sv
// Steps a 0..DUTY_MAX PWM generator to a commanded duty with timed inc/dec presses.
// Optional feature macro: PWM_SEQ_STRICT_RANGE_EN (reject out-of-range targets with err).
module pwm_duty_sequencer
   import pwm_ctrl_pkg::*;
#(
   parameter int                   DUTY_MAX    = PWM_DUTY_MAX,
   parameter int                   DUTY_RST    = PWM_DUTY_RST,
   parameter int                   HOLD_CYCLES = 8,
   parameter logic [PWM_DIV_W-1:0] DIV_RST     = 6'd1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [PWM_DUTY_W-1:0] cmd_duty,
   input  logic [PWM_DIV_W-1:0]  cmd_div,
   output logic                  inc_out,
   output logic                  dec_out,
   output logic [PWM_DIV_W-1:0]  divisor,
   output logic [PWM_DUTY_W-1:0] duty_mirror,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam logic [PWM_DUTY_W-1:0] DUTY_MAX_L = PWM_DUTY_W'(DUTY_MAX);
   localparam logic [PWM_DUTY_W-1:0] DUTY_RST_L = PWM_DUTY_W'(DUTY_RST);

   seq_state_t state_reg, state_next;

   logic [PWM_DUTY_W-1:0] target_reg;
   logic [PWM_DUTY_W-1:0] mirror_reg;
   logic [PWM_DIV_W-1:0]  div_reg;
   logic                  dir_up_reg;
   logic                  inc_reg, dec_reg, done_reg;

   logic                  handshake;
   logic                  out_of_range;
   logic                  reject;
   logic [PWM_DUTY_W-1:0] cmd_target;
   logic                  dir_up_next;
   logic                  inc_next, dec_next, done_next;
   logic                  timer_load, timer_expire;

   assign handshake    = cmd_valid && (state_reg == IDLE);
   assign out_of_range = (cmd_duty > DUTY_MAX_L);
   assign cmd_target   = out_of_range ? DUTY_MAX_L : cmd_duty;

`ifdef PWM_SEQ_STRICT_RANGE_EN
   assign reject = handshake && out_of_range;
`else
   assign reject = 1'b0;
`endif

   // The timer idles at zero and restarts at every phase boundary.
   assign timer_load = (state_reg == IDLE) || timer_expire;

   pwm_seq_timer #(
      .HOLD_CYCLES (HOLD_CYCLES)
   ) u_timer (
      .clk    (clk),
      .rst    (rst),
      .load   (timer_load),
      .expire (timer_expire)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (handshake) begin
               if (reject || (cmd_target == mirror_reg)) state_next = DONE;
               else                                      state_next = PRESS;
            end
         end
         PRESS: begin
            if (timer_expire) state_next = RELEASE;
         end
         RELEASE: begin
            // mirror_reg was already stepped at the end of the press.
            if (timer_expire) begin
               if (mirror_reg == target_reg) state_next = DONE;
               else                          state_next = PRESS;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_comb begin
      dir_up_next = dir_up_reg;
      if (handshake) dir_up_next = (cmd_target > mirror_reg);
      inc_next  = (state_next == PRESS) &&  dir_up_next;
      dec_next  = (state_next == PRESS) && !dir_up_next;
      done_next = (state_next == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         target_reg <= DUTY_RST_L;
         mirror_reg <= DUTY_RST_L;
         div_reg    <= DIV_RST;
         dir_up_reg <= 1'b0;
         inc_reg    <= 1'b0;
         dec_reg    <= 1'b0;
         done_reg   <= 1'b0;
      end else begin
         inc_reg  <= inc_next;
         dec_reg  <= dec_next;
         done_reg <= done_next;
         if (handshake && !reject) begin
            target_reg <= cmd_target;
            div_reg    <= cmd_div;
            dir_up_reg <= dir_up_next;
         end
         if ((state_reg == PRESS) && timer_expire) begin
            mirror_reg <= step_duty(mirror_reg, dir_up_reg, DUTY_MAX_L);
         end
      end
   end

`ifdef PWM_SEQ_STRICT_RANGE_EN
   logic err_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         err_reg <= 1'b0;
      end else begin
         err_reg <= reject;
      end
   end

   assign err = err_reg;
`else
   assign err = 1'b0;
`endif

   assign cmd_ready   = (state_reg == IDLE);
   assign busy        = (state_reg != IDLE);
   assign inc_out     = inc_reg;
   assign dec_out     = dec_reg;
   assign done        = done_reg;
   assign divisor     = div_reg;
   assign duty_mirror = mirror_reg;

endmodule
